cache_controller: RTL and testbench
===================================

// Module: cache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate cache sitting between the CPU data port
//  and the cacheline adaptor. Serves 32-bit CPU loads and stores from a LINE_BITS-wide
//  line array. On a miss it issues whole-line read/write bursts downstream, which the
//  adaptor serializes to physical memory.
// PARAMETERS
//  NUM_SETS   16   number of lines; power of 2, >=2
//  LINE_BITS  256  line width in bits; OFFS = log2(LINE_BITS/8) = 5
//  ADDR_W     32   byte address width; IDX = log2(NUM_SETS), TAG = ADDR_W-IDX-OFFS
// PORTS
//  clk             in   1          system clock, all logic on posedge
//  rst             in   1          synchronous, active-high reset
//  cpu_address     in   ADDR_W     byte address; [1:0] ignored
//  cpu_read        in   1          load request, held high until cpu_resp
//  cpu_write       in   1          store request, held high until cpu_resp
//  cpu_byte_enable in   4          store byte mask
//  cpu_wdata       in   32         store data
//  cpu_rdata       out  32         load data, valid only while cpu_resp=1
//  cpu_resp        out  1          one-cycle completion pulse
//  mem_address     out  ADDR_W     line-aligned address ([OFFS-1:0]=0)
//  mem_read        out  1          line fill request, held until mem_resp
//  mem_write       out  1          line writeback request, held until mem_resp
//  mem_wdata       out  LINE_BITS  victim line, stable while mem_write=1
//  mem_rdata       in   LINE_BITS  fill line, sampled in mem_resp cycle
//  mem_resp        in   1          one-cycle completion of a downstream burst
// BEHAVIOUR
//  - Address split: tag=[ADDR_W-1:IDX+OFFS], index=[IDX+OFFS-1:OFFS], word=[OFFS-1:2].
//  - Storage: per set, data, tag, valid and dirty bits held in flops. rst clears every
//    valid and dirty bit; data and tag arrays are not reset.
//  - Reset values: state=IDLE; cpu_resp, mem_read, mem_write=0; cpu_rdata, mem_address,
//    mem_wdata=0.
//  - FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE.
//    IDLE: if cpu_read|cpu_write, latch address, op, byte enables and wdata; go to COMPARE.
//      If both are high, treat the request as a write.
//    COMPARE: hit = valid & tag match.
//      Read hit: drive selected word on cpu_rdata and pulse cpu_resp; go to IDLE.
//      Write hit: merge wdata into the selected word per byte enable, set dirty, pulse
//      cpu_resp; go to IDLE.
//      Miss with victim valid & dirty: go to WRITEBACK. Any other miss: go to ALLOCATE.
//    WRITEBACK: mem_write=1, mem_address={victim tag,index,0}, mem_wdata=victim line.
//      On mem_resp: deassert next cycle, clear dirty, go to ALLOCATE.
//    ALLOCATE: mem_read=1, mem_address={req tag,index,0}. On mem_resp: write mem_rdata,
//      tag, valid=1, dirty=0; go to COMPARE. The rerun always hits.
//  - mem_read and mem_write are never high together. mem_resp outside
//    WRITEBACK/ALLOCATE is ignored.
//  - Latency (request seen in IDLE at cycle N):
//      hit: cpu_resp at N+1.
//      clean miss: cpu_resp 2 cycles after the fill's mem_resp.
//      dirty miss: writeback, then fill, then the same 2 cycles.
//  - The CPU must hold its inputs stable until cpu_resp. Inputs are latched in IDLE;
//    later changes are ignored for the current request.
//  - Back-to-back requests: after cpu_resp the FSM is in IDLE and may accept a request
//    in the next cycle. The minimum hit-to-hit spacing is 2 cycles.
//  - Reset mid-operation: rst in any state aborts at the next edge. mem_read/mem_write
//    drop, no cpu_resp is issued, and all lines are invalidated. A pending dirty line is
//    lost by design.
// TESTING
//  1. After rst, read 0x40; return a fill with word0=0xDEADBEEF ->
//     mem_read@mem_address=0x40, cpu_rdata=0xDEADBEEF.
//     Then reread 0x40 -> cpu_resp at N+1, mem_read stays 0.
//  2. Line 0x40 holds word1=0xAAAAAAAA; write 0x44, be=0011, wdata=0x12345678 -> hit,
//     no mem traffic. A later read of 0x44 returns 0xAAAA5678.
//  3. With 0x40 dirty from test 2, read 0x244 (same index 2, different tag) ->
//     mem_write at 0x40 carrying the merged line, then mem_read at 0x240, then cpu_resp
//     with the fill's word1.
//  4. Clean conflict: read 0x40 after test 1 only, then read 0x240 -> no mem_write;
//     mem_read at 0x240 only.
//  5. Assert rst during ALLOCATE with mem_read=1 -> mem_read=0 the next cycle, no
//     cpu_resp. A subsequent read of 0x40 misses again.
//  6. cpu_read=cpu_write=1 to 0x48, be=1111, wdata=0x55 -> handled as a write; a later
//     read of 0x48 returns 0x00000055.

Source files
------------

// File: rtl/cache_controller_if.sv
// CPU data port and cacheline-adaptor signals of the cache controller, bundled as one interface.
// The slave view is the cache controller itself; the master view is the CPU/memory environment.
interface cache_controller_if #(
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 256
);
  logic [ADDR_W-1:0]    cpu_address;
  logic                 cpu_read;
  logic                 cpu_write;
  logic [3:0]           cpu_byte_enable;
  logic [31:0]          cpu_wdata;
  logic [31:0]          cpu_rdata;
  logic                 cpu_resp;
  logic [ADDR_W-1:0]    mem_address;
  logic                 mem_read;
  logic                 mem_write;
  logic [LINE_BITS-1:0] mem_wdata;
  logic [LINE_BITS-1:0] mem_rdata;
  logic                 mem_resp;

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_byte_enable, cpu_wdata,
    input  mem_rdata, mem_resp,
    output cpu_rdata, cpu_resp, mem_address, mem_read, mem_write, mem_wdata
  );

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_byte_enable, cpu_wdata,
    output mem_rdata, mem_resp,
    input  cpu_rdata, cpu_resp, mem_address, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache between the CPU data port and the
// cacheline adaptor; whole-line fill and writeback bursts on a miss.
module cache_controller #(
  parameter int NUM_SETS  = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input logic              clk,
  input logic              rst,
  cache_controller_if.slave bus
);
  localparam int OFFS = $clog2(LINE_BITS / 8);
  localparam int IDX  = $clog2(NUM_SETS);
  localparam int TAG  = ADDR_W - IDX - OFFS;
  localparam int WSEL = OFFS - 2;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e state_q, state_d;

  logic [LINE_BITS-1:0] data_q [NUM_SETS];
  logic [TAG-1:0]       tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;

  logic [ADDR_W-1:2] addr_q;
  logic              write_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              fill_done_q;

  logic [TAG-1:0]  req_tag;
  logic [IDX-1:0]  req_idx;
  logic [WSEL-1:0] req_word;
  logic            hit;
  logic [31:0]     cur_word;
  logic [31:0]     merged_word;
  logic            do_fill;
  logic            do_wr_hit;
  logic            clr_dirty;

  assign req_tag  = addr_q[ADDR_W-1 -: TAG];
  assign req_idx  = addr_q[OFFS +: IDX];
  assign req_word = addr_q[2 +: WSEL];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign cur_word = data_q[req_idx][32*req_word +: 32];

  always_comb begin
    merged_word = cur_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be_q[b]) merged_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (state_q == IDLE && (bus.cpu_read || bus.cpu_write)) begin
      addr_q  <= bus.cpu_address[ADDR_W-1:2];
      write_q <= bus.cpu_write;
      be_q    <= bus.cpu_byte_enable;
      wdata_q <= bus.cpu_wdata;
    end
  end

  // The fill is written into the array on mem_resp; one further ALLOCATE cycle with
  // mem_read low follows before the rerun in COMPARE.
  always_ff @(posedge clk) begin
    if (rst) fill_done_q <= 1'b0;
    else     fill_done_q <= do_fill;
  end

  always_ff @(posedge clk) begin
    if (do_fill) begin
      data_q[req_idx] <= bus.mem_rdata;
      tag_q[req_idx]  <= req_tag;
    end else if (do_wr_hit) begin
      data_q[req_idx][32*req_word +: 32] <= merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (do_fill) begin
      valid_q[req_idx] <= 1'b1;
      dirty_q[req_idx] <= 1'b0;
    end else if (do_wr_hit) begin
      dirty_q[req_idx] <= 1'b1;
    end else if (clr_dirty) begin
      dirty_q[req_idx] <= 1'b0;
    end
  end

  always_comb begin
    state_d         = state_q;
    bus.cpu_resp    = 1'b0;
    bus.cpu_rdata   = '0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = '0;
    bus.mem_wdata   = '0;
    do_fill         = 1'b0;
    do_wr_hit       = 1'b0;
    clr_dirty       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cpu_read || bus.cpu_write) state_d = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          bus.cpu_resp = 1'b1;
          if (write_q) do_wr_hit = 1'b1;
          else         bus.cpu_rdata = cur_word;
          state_d = IDLE;
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.mem_write   = 1'b1;
        bus.mem_address = {tag_q[req_idx], req_idx, {OFFS{1'b0}}};
        bus.mem_wdata   = data_q[req_idx];
        if (bus.mem_resp) begin
          clr_dirty = 1'b1;
          state_d   = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (fill_done_q) begin
          state_d = COMPARE;
        end else begin
          bus.mem_read    = 1'b1;
          bus.mem_address = {req_tag, req_idx, {OFFS{1'b0}}};
          if (bus.mem_resp) do_fill = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller: a flat CPU-visible memory plus a per-set
// presence/dirty model predict load data, downstream bursts and response latency.
module tb_cache_controller;
  localparam int NUM_SETS  = 16;
  localparam int LINE_BITS = 256;
  localparam int ADDR_W    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_controller_if #(.ADDR_W(ADDR_W), .LINE_BITS(LINE_BITS)) bus ();

  cache_controller #(
    .NUM_SETS (NUM_SETS),
    .LINE_BITS(LINE_BITS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Backing memory (what the adaptor holds) and the CPU-visible view of memory.
  logic [255:0] mem_store [logic [31:0]];
  logic [31:0]  gold      [logic [31:0]];

  bit          m_valid [NUM_SETS];
  bit          m_dirty [NUM_SETS];
  logic [22:0] m_tag   [NUM_SETS];

  int last_nwb;
  int last_nfill;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem_store.exists(la)) return mem_store[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [31:0] gold_word(input logic [31:0] a);
    logic [31:0]  wa;
    logic [255:0] l;
    wa = {a[31:2], 2'b00};
    if (gold.exists(wa)) return gold[wa];
    l = mem_line({a[31:5], 5'b0});
    return l[32*int'(a[4:2]) +: 32];
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = gold_word(la + 32'(4*w));
    return l;
  endfunction

  function automatic void preload_line(input logic [31:0] la, input logic [255:0] l);
    mem_store[la] = l;
    for (int w = 0; w < 8; w++) gold[la + 32'(4*w)] = l[32*w +: 32];
  endfunction

  // Reset discards every line; modified data that never reached memory is gone.
  function automatic void model_reset();
    logic [31:0]  la;
    logic [255:0] l;
    for (int s = 0; s < NUM_SETS; s++) begin
      if (m_valid[s] && m_dirty[s]) begin
        la = {m_tag[s], 4'(s), 5'b0};
        l  = mem_line(la);
        for (int w = 0; w < 8; w++) gold[la + 32'(4*w)] = l[32*w +: 32];
      end
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endfunction

  task automatic do_reset();
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    bus.mem_resp  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        output logic [31:0] rdata);
    logic [3:0]   s;
    logic [22:0]  t;
    logic [31:0]  wb_la, fill_la, w;
    bit           hit, exp_wb, done;
    int           nwb, nfill, fill_cyc, viol, dly;
    s       = addr[8:5];
    t       = addr[31:9];
    hit     = m_valid[s] && (m_tag[s] == t);
    exp_wb  = !hit && m_valid[s] && m_dirty[s];
    wb_la   = {m_tag[s], s, 5'b0};
    fill_la = {addr[31:5], 5'b0};
    rdata = '0; nwb = 0; nfill = 0; fill_cyc = -10; viol = 0; done = 1'b0;
    dly = int'($urandom_range(0, 3));
    @(negedge clk);
    bus.cpu_address     = addr;
    bus.cpu_read        = rd;
    bus.cpu_write       = wr;
    bus.cpu_byte_enable = be;
    bus.cpu_wdata       = wd;
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(negedge clk);
      bus.mem_resp = 1'b0;
      if (bus.mem_read && bus.mem_write) viol++;
      if (bus.cpu_resp) begin
        done  = 1'b1;
        rdata = bus.cpu_rdata;
        chk("resp_latency", cyc, hit ? 1 : fill_cyc + 2);
        if (!wr) chk("load_data", bus.cpu_rdata, gold_word(addr));
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
      end else if (bus.mem_write || bus.mem_read) begin
        if (dly > 0) dly--;
        else begin
          if (bus.mem_write) begin
            chk("wb_addr", bus.mem_address, wb_la);
            chk("wb_data", bus.mem_wdata, gold_line(wb_la));
            mem_store[bus.mem_address] = bus.mem_wdata;
            nwb++;
          end else begin
            chk("fill_addr", bus.mem_address, fill_la);
            bus.mem_rdata = mem_line(bus.mem_address);
            nfill++;
            fill_cyc = cyc;
          end
          bus.mem_resp = 1'b1;
          dly = int'($urandom_range(0, 3));
        end
      end
    end
    bus.mem_resp  = 1'b0;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    if (!done) chk("resp_timeout", 0, 1);
    chk("rw_exclusive", viol, 0);
    chk("wb_count", nwb, exp_wb);
    chk("fill_count", nfill, !hit);
    last_nwb   = nwb;
    last_nfill = nfill;
    if (!hit) begin
      m_valid[s] = 1'b1;
      m_tag[s]   = t;
      m_dirty[s] = 1'b0;
    end
    if (wr) begin
      w = gold_word(addr);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      gold[{addr[31:2], 2'b00}] = w;
      m_dirty[s] = 1'b1;
    end
  endtask

  initial begin
    logic [255:0] ln;
    logic [31:0]  r, a;
    bit           found;
    int           op;

    rst = 1'b1;
    bus.cpu_address = '0; bus.cpu_read = 1'b0; bus.cpu_write = 1'b0;
    bus.cpu_byte_enable = '0; bus.cpu_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cpu_resp", bus.cpu_resp, 0);
    chk("rst_mem_rw", {bus.mem_read, bus.mem_write}, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    rst = 1'b0;

    ln = mem_line(32'h40);
    ln[31:0]  = 32'hDEADBEEF;
    ln[63:32] = 32'hAAAAAAAA;
    preload_line(32'h40, ln);
    run_op(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, r);
    chk("t1_fill_data", r, 32'hDEADBEEF);
    run_op(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, r);
    chk("t1_reread_data", r, 32'hDEADBEEF);
    chk("t1_reread_no_fill", last_nfill, 0);

    run_op(1'b0, 1'b1, 32'h44, 4'b0011, 32'h12345678, r);
    chk("t2_write_no_traffic", last_nwb + last_nfill, 0);
    run_op(1'b1, 1'b0, 32'h44, 4'h0, 32'h0, r);
    chk("t2_merged_read", r, 32'hAAAA5678);

    run_op(1'b1, 1'b0, 32'h244, 4'h0, 32'h0, r);
    chk("t3_writeback", last_nwb, 1);
    chk("t3_fill", last_nfill, 1);

    do_reset();
    run_op(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, r);
    run_op(1'b1, 1'b0, 32'h240, 4'h0, 32'h0, r);
    chk("t4_clean_no_wb", last_nwb, 0);
    chk("t4_fill", last_nfill, 1);

    do_reset();
    @(negedge clk);
    bus.cpu_address = 32'h40;
    bus.cpu_read    = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_read) found = 1'b1;
    end
    chk("t5_mem_read_seen", found, 1);
    rst = 1'b1;
    bus.cpu_read = 1'b0;
    model_reset();
    @(negedge clk);
    chk("t5_mem_read_drop", bus.mem_read, 0);
    chk("t5_no_resp", bus.cpu_resp, 0);
    rst = 1'b0;
    run_op(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, r);
    chk("t5_miss_again", last_nfill, 1);

    run_op(1'b1, 1'b1, 32'h48, 4'hF, 32'h55, r);
    run_op(1'b1, 1'b0, 32'h48, 4'h0, 32'h0, r);
    chk("t6_both_is_write", r, 32'h00000055);

    for (int i = 0; i < 150; i++) begin
      a  = ($urandom_range(0, 3) << 9) | ($urandom_range(0, NUM_SETS - 1) << 5)
         | ($urandom_range(0, 7) << 2);
      op = int'($urandom_range(0, 3));
      run_op(op != 2, op >= 2, a, 4'($urandom_range(1, 15)), $urandom, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
